// File: rtl/dsi_lane_distributor_pkg.sv
// Shared types and constants for the DSI lane distributor slice.
package dsi_pkg;

  localparam int         DSI_LANES_MAX = 4;
  localparam logic [7:0] DSI_SOT_BYTE  = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HS_WAIT = 3'd1,
    ST_SOT     = 3'd2,
    ST_COLLECT = 3'd3,
    ST_TRAIL   = 3'd4,
    ST_EXIT    = 3'd5
  } dsi_lane_state_t;

  // Lanes 0..lanes_number set; also used for "lanes 0..idx" partial masks.
  function automatic logic [DSI_LANES_MAX-1:0] lane_mask(input logic [1:0] lanes_number);
    logic [DSI_LANES_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < DSI_LANES_MAX; i++) begin
      m[i] = (i <= int'(lanes_number));
    end
    return m;
  endfunction

endpackage

// File: rtl/dsi_lane_distributor_if.sv
// Byte-pull source, HS handshake and lane word bus of the DSI lane distributor.
interface dsi_lane_distributor_if;
  import dsi_pkg::*;

  logic                         src_data_rqst;
  logic [7:0]                   src_input_data;
  logic                         src_start_rqst;
  logic                         src_fin_rqst;
  logic                         hs_rqst;
  logic                         hs_ready;
  logic [8*DSI_LANES_MAX-1:0]   lane_data;
  logic [DSI_LANES_MAX-1:0]     lane_valid;

  modport master (
    output src_data_rqst, hs_rqst, lane_data, lane_valid,
    input  src_input_data, src_start_rqst, src_fin_rqst, hs_ready
  );

  modport slave (
    input  src_data_rqst, hs_rqst, lane_data, lane_valid,
    output src_input_data, src_start_rqst, src_fin_rqst, hs_ready
  );

endinterface

// File: rtl/dsi_lane_distributor_trail_gen.sv
// Per-lane last-bit tracking and HS trail word generation.
module dsi_trail_gen
  import dsi_pkg::*;
#(
  parameter logic [7:0] SOT_BYTE = DSI_SOT_BYTE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init,
  input  logic [DSI_LANES_MAX-1:0]     upd_mask,
  input  logic [8*DSI_LANES_MAX-1:0]   data_word,
  input  logic [DSI_LANES_MAX-1:0]     active_mask,
  output logic [8*DSI_LANES_MAX-1:0]   trail_word
);

  genvar gi;
  generate
    for (gi = 0; gi < DSI_LANES_MAX; gi++) begin : g_lane
      logic last_bit_reg;

      // Only real data bytes update last_bit; trail bytes must not flip it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last_bit_reg <= 1'b0;
        end else if (init) begin
          last_bit_reg <= SOT_BYTE[7];
        end else if (upd_mask[gi]) begin
          last_bit_reg <= data_word[8*gi+7];
        end
      end

      assign trail_word[8*gi +: 8] = active_mask[gi] ? {8{~last_bit_reg}} : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/dsi_lane_distributor.sv
// Pulls packet bytes and spreads them round-robin over 1-4 DSI HS lanes with SoT/trail framing.
// Optional DSI_LANE_STATS_EN adds packet_cnt/byte_cnt statistics outputs.
module dsi_lane_distributor
  import dsi_pkg::*;
#(
  parameter int         LANES_MAX    = DSI_LANES_MAX,
  parameter int         TRAIL_CYCLES = 2,
  parameter logic [7:0] SOT_BYTE     = DSI_SOT_BYTE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              lanes_number,
  dsi_lane_distributor_if.master  bus,
  output logic                    busy
`ifdef DSI_LANE_STATS_EN
  ,
  output logic [15:0]             packet_cnt,
  output logic [23:0]             byte_cnt
`endif
);

  localparam logic [2:0] TRAIL_LAST = 3'(TRAIL_CYCLES - 1);

  dsi_lane_state_t          state_reg, state_next;
  logic [1:0]               n_m1_reg;
  logic [LANES_MAX-1:0]     mask_reg;
  logic [1:0]               idx_reg;
  logic [7:0]               slot_reg [LANES_MAX];
  logic [2:0]               trail_cnt_reg;
  logic [8*LANES_MAX-1:0]   lane_data_reg, lane_data_next;
  logic [LANES_MAX-1:0]     lane_valid_reg, lane_valid_next;

  logic                     hs_rqst;
  logic                     src_data_rqst;
  logic                     consume;
  logic                     word_done;
  logic                     sot_load;
  logic [LANES_MAX-1:0]     data_lanes;
  logic [8*LANES_MAX-1:0]   sot_word;
  logic [8*LANES_MAX-1:0]   fill_word;
  logic [8*LANES_MAX-1:0]   trail_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hs_rqst       = 1'b0;
    src_data_rqst = 1'b0;
    busy          = 1'b1;
    unique case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.src_start_rqst) state_next = ST_HS_WAIT;
      end
      ST_HS_WAIT: begin
        hs_rqst = 1'b1;
        if (bus.hs_ready) state_next = ST_SOT;
      end
      ST_SOT: begin
        hs_rqst    = 1'b1;
        state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        hs_rqst       = 1'b1;
        src_data_rqst = 1'b1;
        if (bus.src_fin_rqst) state_next = ST_TRAIL;
      end
      ST_TRAIL: begin
        hs_rqst = 1'b1;
        if (trail_cnt_reg == TRAIL_LAST) state_next = ST_EXIT;
      end
      ST_EXIT: begin
        if (!bus.hs_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign consume    = (state_reg == ST_COLLECT);
  assign word_done  = consume && (bus.src_fin_rqst || (idx_reg == n_m1_reg));
  assign sot_load   = (state_reg == ST_HS_WAIT) && bus.hs_ready;
  assign data_lanes = lane_mask(idx_reg);

  // The byte arriving this cycle bypasses its slot so the word leaves one cycle after the fill.
  genvar gi;
  generate
    for (gi = 0; gi < LANES_MAX; gi++) begin : g_word
      assign sot_word[8*gi +: 8]  = mask_reg[gi] ? SOT_BYTE : 8'h00;
      assign fill_word[8*gi +: 8] = !data_lanes[gi]      ? trail_word[8*gi +: 8] :
                                    (idx_reg == 2'(gi))  ? bus.src_input_data    :
                                                           slot_reg[gi];
    end
  endgenerate

  dsi_trail_gen #(
    .SOT_BYTE (SOT_BYTE)
  ) u_trail_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .init        (sot_load),
    .upd_mask    (word_done ? data_lanes : '0),
    .data_word   (fill_word),
    .active_mask (mask_reg),
    .trail_word  (trail_word)
  );

  always_comb begin
    lane_data_next  = '0;
    lane_valid_next = '0;
    if (sot_load) begin
      lane_data_next  = sot_word;
      lane_valid_next = mask_reg;
    end else if (word_done) begin
      lane_data_next  = fill_word;
      lane_valid_next = mask_reg;
    end else if (state_reg == ST_TRAIL) begin
      lane_data_next  = trail_word;
      lane_valid_next = mask_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_m1_reg       <= '0;
      mask_reg       <= '0;
      idx_reg        <= '0;
      trail_cnt_reg  <= '0;
      lane_data_reg  <= '0;
      lane_valid_reg <= '0;
      for (int i = 0; i < LANES_MAX; i++) slot_reg[i] <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && bus.src_start_rqst) begin
        n_m1_reg <= lanes_number;
        mask_reg <= lane_mask(lanes_number);
      end
      if (state_reg == ST_SOT) begin
        idx_reg <= '0;
      end else if (consume) begin
        idx_reg <= word_done ? 2'd0 : idx_reg + 2'd1;
      end
      if (consume) slot_reg[idx_reg] <= bus.src_input_data;
      trail_cnt_reg  <= (state_reg == ST_TRAIL) ? trail_cnt_reg + 3'd1 : 3'd0;
      lane_data_reg  <= lane_data_next;
      lane_valid_reg <= lane_valid_next;
    end
  end

  assign bus.hs_rqst       = hs_rqst;
  assign bus.src_data_rqst = src_data_rqst;
  assign bus.lane_data     = lane_data_reg;
  assign bus.lane_valid    = lane_valid_reg;

`ifdef DSI_LANE_STATS_EN
  logic [15:0] packet_cnt_reg;
  logic [23:0] byte_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packet_cnt_reg <= '0;
      byte_cnt_reg   <= '0;
    end else begin
      if ((state_reg == ST_TRAIL) && (state_next == ST_EXIT)) packet_cnt_reg <= packet_cnt_reg + 16'd1;
      if (consume) byte_cnt_reg <= byte_cnt_reg + 24'd1;
    end
  end

  assign packet_cnt = packet_cnt_reg;
  assign byte_cnt   = byte_cnt_reg;
`endif

endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Self-checking bench for dsi_lane_distributor: directed table, corner sequences, random packets vs model.
module tb_dsi_lane_distributor;
  import dsi_pkg::*;

  localparam int TRAIL_CYCLES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] lanes_number = 2'd0;
  logic       busy;
`ifdef DSI_LANE_STATS_EN
  logic [15:0] packet_cnt;
  logic [23:0] byte_cnt;
`endif

  dsi_lane_distributor_if bus ();

  dsi_lane_distributor #(
    .TRAIL_CYCLES (TRAIL_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lanes_number (lanes_number),
    .bus          (bus),
    .busy         (busy)
`ifdef DSI_LANE_STATS_EN
    ,
    .packet_cnt   (packet_cnt),
    .byte_cnt     (byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        ln;
    logic [3:0]        len;
    logic [2:0]        hs_dly;
    logic [63:0]       bytes;
    logic [2:0]        nw;
    logic [5:0][31:0]  words;
    logic [3:0]        valid;
  } vec_t;

  vec_t        vecs [3];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulled;
  int          exp_pkts  = 0;
  int          exp_bytes = 0;
  logic [7:0]  pkt [0:31];
  logic [31:0] cap_data[$];
  logic [3:0]  cap_valid[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_valid[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: SoT word, then the packet cut into N-byte chunks, then trail words.
  task automatic build_exp(input logic [1:0] ln, input int len);
    int          n;
    logic [31:0] w;
    logic [3:0]  vm;
    bit          last [4];
    n  = int'(ln) + 1;
    vm = 4'((1 << n) - 1);
    exp_data.delete();
    exp_valid.delete();
    w = '0;
    for (int k = 0; k < n; k++) w |= 32'(DSI_SOT_BYTE) << (8 * k);
    exp_data.push_back(w);
    exp_valid.push_back(vm);
    for (int k = 0; k < 4; k++) last[k] = DSI_SOT_BYTE[7];
    for (int c = 0; c < len; c += n) begin
      w = '0;
      for (int k = 0; k < n; k++) begin
        if (c + k < len) w |= 32'(pkt[c + k]) << (8 * k);
        else             w |= 32'(last[k] ? 8'h00 : 8'hFF) << (8 * k);
      end
      for (int k = 0; k < n; k++) if (c + k < len) last[k] = pkt[c + k][7];
      exp_data.push_back(w);
      exp_valid.push_back(vm);
    end
    for (int t = 0; t < TRAIL_CYCLES; t++) begin
      w = '0;
      for (int k = 0; k < n; k++) w |= 32'(last[k] ? 8'h00 : 8'hFF) << (8 * k);
      exp_data.push_back(w);
      exp_valid.push_back(vm);
    end
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, " word_count"}, 32'(cap_data.size()), 32'(exp_data.size()));
    m = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s w%0d data", tag, i), cap_data[i], exp_data[i]);
      check($sformatf("%s w%0d valid", tag, i), 32'(cap_valid[i]), 32'(exp_valid[i]));
    end
    $display("packet %s: %0d words captured, %0d expected", tag, cap_data.size(), exp_data.size());
  endtask

  // Drives one packet from pkt[], acting as both repacker and PHY; captures all lane words.
  task automatic run_packet(input string tag, input logic [1:0] ln, input int len,
                            input int hs_dly, input bit midstart);
    int pos = 0, hcnt = 0, xcnt = 0;
    bit seen = 0, done = 0, ms = 0, exit_chk = 0;
    cap_data.delete();
    cap_valid.delete();
    pulled = 0;
    @(negedge clk);
    lanes_number = ln;
    bus.src_start_rqst = 1'b1;
    @(negedge clk);
    bus.src_start_rqst = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (bus.lane_valid != 4'd0) begin
        cap_data.push_back(bus.lane_data);
        cap_valid.push_back(bus.lane_valid);
      end
      if (busy) seen = 1;
      else if (seen) done = 1;
      bus.src_start_rqst = 1'b0;
      if (bus.src_data_rqst) begin
        if (midstart && pos == 2 && !ms) begin
          bus.src_start_rqst = 1'b1;
          lanes_number = ~ln;
          ms = 1;
        end
        bus.src_input_data = (pos < len) ? pkt[pos] : 8'h00;
        bus.src_fin_rqst   = (pos == len - 1);
        pos++;
        pulled++;
      end else begin
        bus.src_input_data = 8'h00;
        bus.src_fin_rqst   = 1'b0;
      end
      if (bus.hs_rqst && !bus.hs_ready) begin
        if (hcnt >= hs_dly) bus.hs_ready = 1'b1;
        else hcnt++;
      end else if (!bus.hs_rqst && bus.hs_ready) begin
        if (!exit_chk) begin
          check({tag, " busy_in_exit"}, 32'(busy), 32'd1);
          exit_chk = 1;
        end
        if (xcnt >= 1) bus.hs_ready = 1'b0;
        else xcnt++;
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: busy never returned low, required completion in 400 cycles", tag);
    end
    check({tag, " bytes_pulled"}, 32'(pulled), 32'(len));
    check({tag, " hs_rqst_end"}, 32'(bus.hs_rqst), 32'd0);
    exp_pkts++;
    exp_bytes += len;
  endtask

  task automatic reset_mid_packet();
    int pos = 0;
    bit hit = 0;
    for (int i = 0; i < 8; i++) pkt[i] = 8'(8'h40 + i);
    @(negedge clk);
    lanes_number = 2'd0;
    bus.src_start_rqst = 1'b1;
    @(negedge clk);
    bus.src_start_rqst = 1'b0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      if (bus.src_data_rqst) begin
        bus.src_input_data = pkt[pos];
        bus.src_fin_rqst   = 1'b0;
        pos++;
        if (pos == 3) hit = 1;
      end
      if (bus.hs_rqst && !bus.hs_ready) bus.hs_ready = 1'b1;
      if (!hit) @(negedge clk);
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL rst_mid timeout: COLLECT not reached, required within 100 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid lane_data",  bus.lane_data, 32'd0);
    check("rst_mid lane_valid", 32'(bus.lane_valid), 32'd0);
    check("rst_mid hs_rqst",    32'(bus.hs_rqst), 32'd0);
    check("rst_mid data_rqst",  32'(bus.src_data_rqst), 32'd0);
    check("rst_mid busy",       32'(busy), 32'd0);
    bus.hs_ready       = 1'b0;
    bus.src_input_data = 8'h00;
    bus.src_fin_rqst   = 1'b0;
    exp_pkts  = 0;
    exp_bytes = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("packet rst_mid: reset asserted after 3 bytes");
  endtask

  initial begin
    int ln, len, dly;

    vecs[0] = '{ln: 2'd3, len: 4'd8, hs_dly: 3'd3, bytes: 64'h0807060504030201, nw: 3'd5,
                words: {32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h08070605, 32'h04030201, 32'hB8B8B8B8},
                valid: 4'hF};
    vecs[1] = '{ln: 2'd1, len: 4'd3, hs_dly: 3'd1, bytes: 64'h0000000000FF0180, nw: 3'd5,
                words: {32'h0, 32'h0000FF00, 32'h0000FF00, 32'h0000FFFF, 32'h00000180, 32'h0000B8B8},
                valid: 4'h3};
    vecs[2] = '{ln: 2'd0, len: 4'd1, hs_dly: 3'd0, bytes: 64'h000000000000007F, nw: 3'd4,
                words: {32'h0, 32'h0, 32'h000000FF, 32'h000000FF, 32'h0000007F, 32'h000000B8},
                valid: 4'h1};

    bus.src_input_data = 8'h00;
    bus.src_start_rqst = 1'b0;
    bus.src_fin_rqst   = 1'b0;
    bus.hs_ready       = 1'b0;

    repeat (3) @(negedge clk);
    check("reset lane_data",  bus.lane_data, 32'd0);
    check("reset lane_valid", 32'(bus.lane_valid), 32'd0);
    check("reset hs_rqst",    32'(bus.hs_rqst), 32'd0);
    check("reset data_rqst",  32'(bus.src_data_rqst), 32'd0);
    check("reset busy",       32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 8; b++) pkt[b] = vecs[i].bytes[8*b +: 8];
      run_packet($sformatf("vec%0d", i), vecs[i].ln, int'(vecs[i].len), int'(vecs[i].hs_dly), 1'b0);
      exp_data.delete();
      exp_valid.delete();
      for (int w = 0; w < int'(vecs[i].nw); w++) begin
        exp_data.push_back(vecs[i].words[w]);
        exp_valid.push_back(vecs[i].valid);
      end
      compare($sformatf("vec%0d", i));
    end

`ifdef DSI_LANE_STATS_EN
    check("stats packet_cnt", 32'(packet_cnt), 32'd3);
    check("stats byte_cnt",   32'(byte_cnt), 32'd12);
`endif

    // Start pulse and lanes_number change while collecting must not disturb the packet.
    for (int i = 0; i < 6; i++) pkt[i] = 8'(8'hA0 + 8'(i * 17));
    run_packet("midstart", 2'd1, 6, 2, 1'b1);
    build_exp(2'd1, 6);
    compare("midstart");
    for (int i = 0; i < 5; i++) pkt[i] = 8'(8'h11 * (i + 1));
    run_packet("newlanes", lanes_number, 5, 1, 1'b0);
    build_exp(2'd2, 5);
    compare("newlanes");

    reset_mid_packet();
    for (int i = 0; i < 7; i++) pkt[i] = 8'(8'hF0 - 8'(i * 33));
    run_packet("post_rst", 2'd2, 7, 2, 1'b0);
    build_exp(2'd2, 7);
    compare("post_rst");

    for (int r = 0; r < 20; r++) begin
      ln  = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 20));
      dly = int'($urandom_range(0, 4));
      for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
      run_packet($sformatf("rnd%0d", r), 2'(ln), len, dly, 1'b0);
      build_exp(2'(ln), len);
      compare($sformatf("rnd%0d", r));
    end

`ifdef DSI_LANE_STATS_EN
    check("stats_end packet_cnt", 32'(packet_cnt), 32'(exp_pkts));
    check("stats_end byte_cnt",   32'(byte_cnt), 32'(exp_bytes));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded 2 ms, required completion earlier");
    $fatal(1, "global timeout");
  end

endmodule
